fetch_pc_ctrl: RTL and testbench
================================

Name: fetch_pc_ctrl

Overview:
Sequencer for the Fetch stage. Owns the PC register and drives the instruction-memory request/ready handshake. Selects the next PC from three sources, in priority order: redirect (branch or jump resolved downstream), stall hold, and sequential PC+4. Emits the IF/ID valid and flush controls and sits between hazard/branch logic and instruction memory.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
PC_STEP, 4, sequential increment in bytes.
XLEN, 32, PC and address width.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
stall  input  1  hazard unit hold request for IF.
redir_valid  input  1  one-cycle redirect request from EX/MEM.
redir_target  input  XLEN  redirect destination PC.
imem_ready  input  1  instruction memory returns data this cycle.
imem_req  output  1  fetch request valid.
imem_addr  output  XLEN  fetch address; always equals pc.
pc  output  XLEN  current PC register.
pc_plus4  output  XLEN  pc + PC_STEP, to IF/ID.
if_valid  output  1  fetched instruction accepted into IF/ID this cycle.
ifid_flush  output  1  kill IF/ID contents.
redir_misalign  output  1  redirect target had nonzero bits [1:0].
fetch_count  output  32  number of completed fetches.

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on posedge clk.
- Reset (rst=1 at an edge, overrides everything):
  - pc=RESET_PC, state=BOOT, fetch_count=0.
  - imem_req, if_valid, ifid_flush and redir_misalign are all 0 in the cycle after reset.
  - Reset asserted mid-WAIT or mid-FLUSH abandons the fetch. No if_valid is produced.
- States: BOOT, RUN, WAIT, FLUSH.
- BOOT: imem_req=0. Next state is RUN.
- RUN and WAIT: imem_req=1, imem_addr=pc. A fetch completes when imem_req && imem_ready.
  - Complete && !stall && !redir_valid: if_valid=1 (combinational, same cycle); pc <= pc+PC_STEP; fetch_count += 1; next state RUN.
  - Complete && stall && !redir_valid: if_valid=0; pc held; next state RUN. The same address is refetched.
  - !imem_ready && !redir_valid: pc held; next state WAIT. Stall has no further effect while waiting.
- Redirect (redir_valid=1 in BOOT, RUN, WAIT or FLUSH):
  - pc <= {redir_target[XLEN-1:2],2'b00}; next state FLUSH.
  - ifid_flush=1 and if_valid=0 that cycle, even if imem_ready=1. fetch_count does not increment.
  - Redirect overrides stall.
  - redir_misalign=1 that cycle iff redir_target[1:0]!=0 (combinational, not sticky).
- FLUSH: imem_req=0 (one bubble); ifid_flush=0 unless a new redirect arrives. Next state RUN. A redirect in FLUSH reloads pc and stays in FLUSH.
- Outputs are 0 outside the conditions above.
- pc_plus4 = pc + PC_STEP, truncated to XLEN. 32'hFFFF_FFFC+4 wraps to 0. fetch_count wraps 2^32-1 -> 0.
- Latency: a redirect at cycle N gives imem_addr=target at N+1 (FLUSH, no request) and the first request at N+2.
- imem_ready outside RUN/WAIT is ignored.

Decomposition:
- Shared package fetch_pkg: state enum (BOOT, RUN, WAIT, FLUSH), RESET_PC default, PC_STEP, XLEN.
- One sub-module: instantiate the existing Fetch-stage adder module to produce pc_plus4.
- Next-PC mux, FSM and counter stay in this module.

Test Plan:
1. Reset, then imem_ready=1 held, no stall -> BOOT one cycle; pc sequence 0,4,8,12 on consecutive cycles; if_valid=1 each; fetch_count=3 after 3 fetches.
2. stall=1 for 3 cycles at pc=0x10 with imem_ready=1 -> pc stays 0x10, if_valid=0; on release pc=0x14 next cycle; fetch_count +1 only.
3. imem_ready=0 for 2 cycles at pc=0x20 -> WAIT, imem_req=1, addr 0x20 held; ready=1 -> if_valid=1, pc=0x24.
4. redir_valid with target 0x103 during WAIT at pc=0x40 -> ifid_flush=1, redir_misalign=1, if_valid=0; next cycle imem_req=0 and pc=0x100; following cycle request to 0x100.
5. Back-to-back redirects: 0x200 then 0x300 in FLUSH -> ifid_flush both cycles; first request issued to 0x300.
6. pc reaches 0xFFFF_FFFC via redirect, fetch completes -> pc=0x0, pc_plus4=0x4. rst=1 mid-WAIT -> pc=RESET_PC, no if_valid.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared constants and state encoding for the Fetch-stage
//            PC sequencer.
// Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

    // Default datapath width, reset vector and sequential step.
    localparam int          FETCH_XLEN     = 32;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam int          FETCH_PC_STEP  = 4;

    // Fetch sequencer state encoding.
    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_BOOT  = 2'd0;  // post-reset bubble
    localparam fetch_state_t ST_RUN   = 2'd1;  // issuing requests
    localparam fetch_state_t ST_WAIT  = 2'd2;  // request outstanding, memory not ready
    localparam fetch_state_t ST_FLUSH = 2'd3;  // one-cycle bubble after a redirect

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_pc_ctrl_adder.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_ctrl_adder
// Purpose  : Fetch-stage sequential-PC adder. Produces pc + STEP, wrapping
//            modulo 2^XLEN.
// Revision : 1.0  initial release
// ============================================================================
module fetch_pc_ctrl_adder #(
    parameter int XLEN = 32,
    parameter int STEP = 4
) (
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] sum_o
);

    localparam logic [XLEN-1:0] c_STEP = XLEN'(STEP);

    // Plain truncating add; the carry out of the top bit is deliberately dropped.
    assign sum_o = pc_i + c_STEP;

endmodule : fetch_pc_ctrl_adder
`default_nettype wire

// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_ctrl
// Purpose  : Fetch-stage sequencer. Owns the PC, drives the instruction
//            memory request/ready handshake, selects next PC (redirect >
//            stall hold > sequential) and produces IF/ID valid/flush.
// Revision : 1.0  initial release
// ============================================================================
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter int              XLEN     = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC),
    parameter int              PC_STEP  = FETCH_PC_STEP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_target,
    input  logic            imem_ready,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            if_valid,
    output logic            ifid_flush,
    output logic            redir_misalign,
    output logic [31:0]     fetch_count
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     cnt_q, cnt_d;

    logic [XLEN-1:0] w_pc_seq;
    logic [XLEN-1:0] w_redir_pc;
    logic            w_fetching;
    logic            w_complete;

    // Sequential PC comes from the shared Fetch adder.
    fetch_pc_ctrl_adder #(
        .XLEN (XLEN),
        .STEP (PC_STEP)
    ) u_adder (
        .pc_i  (pc_q),
        .sum_o (w_pc_seq)
    );

    // Redirect targets are forced to a word boundary; misalignment is only flagged.
    assign w_redir_pc = {redir_target[XLEN-1:2], 2'b00};

    // Requests are live only in RUN and WAIT; memory ready elsewhere is ignored.
    assign w_fetching = (state_q == ST_RUN) || (state_q == ST_WAIT);
    assign w_complete = w_fetching && imem_ready;

    // Next-state, next-PC and fetch-counter selection.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (redir_valid) begin
            pc_d    = w_redir_pc;
            state_d = ST_FLUSH;
        end else begin
            case (state_q)
                ST_BOOT,
                ST_FLUSH: state_d = ST_RUN;
                ST_RUN,
                ST_WAIT: begin
                    if (imem_ready) begin
                        state_d = ST_RUN;
                        // A stalled completion is discarded and the same address refetched.
                        if (!stall) begin
                            pc_d  = w_pc_seq;
                            cnt_d = cnt_q + 32'd1;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake/control outputs are suppressed while reset is asserted so an
    // in-flight fetch is abandoned without producing a valid.
    assign imem_req       = w_fetching && !rst;
    assign if_valid       = w_complete && !stall && !redir_valid && !rst;
    assign ifid_flush     = redir_valid && !rst;
    assign redir_misalign = redir_valid && (redir_target[1:0] != 2'b00) && !rst;

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = w_pc_seq;
    assign fetch_count = cnt_q;

endmodule : fetch_pc_ctrl
`default_nettype wire

// File: tb/tb_fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_ctrl
// Purpose  : Self-checking bench for fetch_pc_ctrl: behavioural model checked
//            every cycle plus hand-computed literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_pc_ctrl;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        if_valid;
    logic        ifid_flush;
    logic        redir_misalign;
    logic [31:0] fetch_count;

    int n_vec = 0;
    int n_err = 0;

    fetch_pc_ctrl #(
        .XLEN     (32),
        .RESET_PC (c_RESET_PC),
        .PC_STEP  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redir_valid    (redir_valid),
        .redir_target   (redir_target),
        .imem_ready     (imem_ready),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .if_valid       (if_valid),
        .ifid_flush     (ifid_flush),
        .redir_misalign (redir_misalign),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model only knows: the PC, the completed-fetch count, and whether
    // the coming cycle is a no-request bubble (after reset or a redirect).
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_bubble;
    bit          m_init = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_pc     = c_RESET_PC;
            m_cnt    = 32'd0;
            m_bubble = 1'b1;
            m_init   = 1'b1;
        end else if (m_init) begin
            if (redir_valid) begin
                m_pc     = redir_target & ~32'h3;
                m_bubble = 1'b1;
            end else if (m_bubble) begin
                m_bubble = 1'b0;
            end else if (imem_ready && !stall) begin
                m_pc  = m_pc + 32'd4;
                m_cnt = m_cnt + 32'd1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_init) begin
            logic e_req;
            e_req = !rst && !m_bubble;
            chk("imem_req",       {31'd0, imem_req},       {31'd0, e_req});
            chk("imem_addr",      imem_addr,               m_pc);
            chk("pc",             pc,                      m_pc);
            chk("pc_plus4",       pc_plus4,                m_pc + 32'd4);
            chk("if_valid",       {31'd0, if_valid},
                {31'd0, e_req && imem_ready && !stall && !redir_valid});
            chk("ifid_flush",     {31'd0, ifid_flush},     {31'd0, !rst && redir_valid});
            chk("redir_misalign", {31'd0, redir_misalign},
                {31'd0, !rst && redir_valid && (redir_target[1:0] != 2'b00)});
            chk("fetch_count",    fetch_count,             m_cnt);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic s, input logic rv, input logic [31:0] t, input logic rdy);
        stall        = s;
        redir_valid  = rv;
        redir_target = t;
        imem_ready   = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        // Reset state: BOOT bubble
        chk("lit_reset_pc",  pc,                   32'h0);
        chk("lit_reset_req", {31'd0, imem_req},    32'd0);
        chk("lit_reset_cnt", fetch_count,          32'd0);
        chk("lit_reset_val", {31'd0, if_valid},    32'd0);

        // 1: sequential fetch
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        chk("lit_t1_pc0",  pc,                32'h0);
        chk("lit_t1_req",  {31'd0, imem_req}, 32'd1);
        chk("lit_t1_val",  {31'd0, if_valid}, 32'd1);
        repeat (3) tick();
        chk("lit_t1_pc12", pc,          32'hC);
        chk("lit_t1_cnt",  fetch_count, 32'd3);
        tick();

        // 2: stall at 0x10
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        #1;
        chk("lit_t2_stval", {31'd0, if_valid}, 32'd0);
        repeat (3) tick();
        chk("lit_t2_hold", pc,          32'h10);
        chk("lit_t2_cnt",  fetch_count, 32'd4);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        chk("lit_t2_relval", {31'd0, if_valid}, 32'd1);
        tick();
        chk("lit_t2_pc", pc,          32'h14);
        chk("lit_t2_c5", fetch_count, 32'd5);
        repeat (3) tick();

        // 3: memory wait at 0x20
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (2) tick();
        chk("lit_t3_addr", imem_addr,         32'h20);
        chk("lit_t3_req",  {31'd0, imem_req}, 32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        chk("lit_t3_val", {31'd0, if_valid}, 32'd1);
        tick();
        chk("lit_t3_pc", pc, 32'h24);
        repeat (7) tick();

        // 4: misaligned redirect during WAIT at 0x40
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk("lit_t4_pc40", pc, 32'h40);
        drive(1'b1, 1'b1, 32'h103, 1'b1);
        #1;
        chk("lit_t4_flush", {31'd0, ifid_flush},     32'd1);
        chk("lit_t4_mis",   {31'd0, redir_misalign}, 32'd1);
        chk("lit_t4_val",   {31'd0, if_valid},       32'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        chk("lit_t4_bubreq", {31'd0, imem_req},   32'd0);
        chk("lit_t4_pc",     pc,                  32'h100);
        chk("lit_t4_nofl",   {31'd0, ifid_flush}, 32'd0);
        tick();
        chk("lit_t4_req",  {31'd0, imem_req}, 32'd1);
        chk("lit_t4_addr", imem_addr,         32'h100);
        chk("lit_t4_cnt",  fetch_count,       32'd16);

        // 5: back-to-back redirects
        drive(1'b0, 1'b1, 32'h200, 1'b1);
        #1;
        chk("lit_t5_mis0", {31'd0, redir_misalign}, 32'd0);
        tick();
        drive(1'b0, 1'b1, 32'h300, 1'b0);
        #1;
        chk("lit_t5_flush2", {31'd0, ifid_flush}, 32'd1);
        chk("lit_t5_req0",   {31'd0, imem_req},   32'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk("lit_t5_req",  {31'd0, imem_req}, 32'd1);
        chk("lit_t5_addr", imem_addr,         32'h300);
        chk("lit_t5_cnt",  fetch_count,       32'd16);

        // 6: wrap at top of address space, then reset mid-WAIT
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        chk("lit_t6_top",  pc,       32'hFFFF_FFFC);
        chk("lit_t6_p4w",  pc_plus4, 32'h0);
        tick();
        chk("lit_t6_wrap", pc,          32'h0);
        chk("lit_t6_p4",   pc_plus4,    32'h4);
        chk("lit_t6_cnt",  fetch_count, 32'd17);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        chk("lit_t6_rstval", {31'd0, if_valid}, 32'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("lit_t6_rpc",  pc,                c_RESET_PC);
        chk("lit_t6_rcnt", fetch_count,       32'd0);
        chk("lit_t6_rreq", {31'd0, imem_req}, 32'd0);
        repeat (3) tick();

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fetch_pc_ctrl
`default_nettype wire
